// File: rtl/eth_pkg.sv
// Shared types, frame constants and the reflected CRC-32 byte step for the Ethernet frame packer.
package eth_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, FCS, GAP} state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int HDR_LEN      = 16;
  localparam int FCS_LEN      = 4;
  localparam int IFG_LEN      = 12;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_R    = 32'hEDB8_8320;

  // One byte of IEEE 802.3 CRC, LSB first, unrolled to eight shift/xor steps.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator: result registered one cycle after en; init/reset load all-ones.
// No backpressure: d is consumed on every cycle en is high.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk125,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk125) begin
    if (reset || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step(crc, d);
    end
  end

endmodule

// File: rtl/eth_frame_packer.sv
// Streams Ethernet II frames built from 40-bit FIFO words, one registered byte per cycle, 1-cycle start latency.
// No backpressure: once started a frame always runs to completion; the FIFO must already hold WORDS words.
module eth_frame_packer
  import eth_pkg::*;
#(
  parameter int          WORDS   = 256,
  parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [15:0] ETYPE   = 16'h88B5
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        afull,
  output logic        rden,
  input  logic [39:0] q,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_er
);

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
  localparam logic [10:0] PAY_LAST = 11'(5 * WORDS - 1);
  localparam logic [10:0] FCS_LAST = 11'(FCS_LEN - 1);
  localparam logic [10:0] GAP_LAST = 11'(IFG_LEN - 1);
  localparam logic [10:0] RD_FIRST = 11'(HDR_LEN - 3);
  localparam logic [10:0] RD_STOP  = 11'(5 * WORDS - 5);

  // state/cnt/ph describe the byte currently on tx_data; the nxt_* values pick the next one.
  state_t        state, nxt_state;
  logic [10:0]   cnt, nxt_cnt;
  logic [2:0]    ph, nxt_ph;
  logic [39:0]   sreg, nxt_sreg;
  logic [15:0]   seq, nxt_seq;
  logic [7:0]    nxt_byte;
  logic          nxt_en, nxt_rden;
  logic          crc_init, crc_en;
  logic [31:0]   crc, crc_inv;
  logic [127:0]  hdr_vec;
  logic [3:0]    hdr_idx;

  assign hdr_vec = {DST_MAC, SRC_MAC, ETYPE, seq};
  assign hdr_idx = ~nxt_cnt[3:0];
  assign crc_inv = ~crc;
  assign tx_er   = 1'b0;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 11'd1;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (afull) nxt_state = PRE;
      end
      PRE:  if (cnt == PRE_LAST) begin nxt_state = HDR;  nxt_cnt = '0; end
      HDR:  if (cnt == HDR_LAST) begin nxt_state = PAY;  nxt_cnt = '0; end
      PAY:  if (cnt == PAY_LAST) begin nxt_state = FCS;  nxt_cnt = '0; end
      FCS:  if (cnt == FCS_LAST) begin nxt_state = GAP;  nxt_cnt = '0; end
      GAP:  if (cnt == GAP_LAST) begin nxt_state = IDLE; nxt_cnt = '0; end
      default: begin nxt_state = IDLE; nxt_cnt = '0; end
    endcase
    nxt_ph  = (state != PAY || ph == 3'd4) ? 3'd0 : ph + 3'd1;
    nxt_seq = (state == FCS && cnt == FCS_LAST) ? seq + 16'd1 : seq;
  end

  // A word is requested three cycles before its first byte goes out; Q is held by the FIFO until then.
  always_comb begin
    nxt_byte = '0;
    nxt_sreg = sreg;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    unique case (nxt_state)
      PRE: begin
        nxt_byte = (nxt_cnt == PRE_LAST) ? SFD : PREAMBLE_BYTE;
        crc_init = 1'b1;
      end
      HDR: begin
        nxt_byte = hdr_vec[{hdr_idx, 3'b000} +: 8];
        crc_en   = 1'b1;
      end
      PAY: begin
        if (nxt_ph == 3'd0) begin
          nxt_byte = q[39:32];
          nxt_sreg = {q[31:0], 8'h00};
        end else begin
          nxt_byte = sreg[39:32];
          nxt_sreg = {sreg[31:0], 8'h00};
        end
        crc_en = 1'b1;
      end
      FCS:     nxt_byte = crc_inv[{nxt_cnt[1:0], 3'b000} +: 8];
      default: nxt_byte = '0;
    endcase
    nxt_en   = (nxt_state == PRE) || (nxt_state == HDR) || (nxt_state == PAY) || (nxt_state == FCS);
    nxt_rden = (nxt_state == HDR && nxt_cnt == RD_FIRST) ||
               (nxt_state == PAY && nxt_ph == 3'd2 && nxt_cnt < RD_STOP);
  end

  always_ff @(posedge clk125) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ph      <= '0;
      sreg    <= '0;
      seq     <= '0;
      tx_data <= '0;
      tx_en   <= 1'b0;
      rden    <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      ph      <= nxt_ph;
      sreg    <= nxt_sreg;
      seq     <= nxt_seq;
      tx_data <= nxt_byte;
      tx_en   <= nxt_en;
      rden    <= nxt_rden;
    end
  end

  crc32_d8 u_crc (
    .clk125 (clk125),
    .reset  (reset),
    .init   (crc_init),
    .en     (crc_en),
    .d      (nxt_byte),
    .crc    (crc)
  );

endmodule

// File: tb/tb_eth_frame_packer.sv
// Bench for eth_frame_packer with a non-FWFT FIFO model, a frame monitor and a byte-level frame reference.
module tb_eth_frame_packer;

  localparam int W    = 9;
  localparam int FLEN = 28 + 5 * W;

  logic        clk125 = 1'b0;
  logic        reset  = 1'b1;
  logic        afull  = 1'b0;
  logic        rden;
  logic [39:0] q = '0;
  logic [7:0]  tx_data;
  logic        tx_en, tx_er;

  logic        c_init = 1'b1, c_en = 1'b0;
  logic [7:0]  c_d = '0;
  logic [31:0] c_crc;

  int checks = 0;
  int failures = 0;

  always #4 clk125 = ~clk125;

  eth_frame_packer #(.WORDS(W)) dut (
    .clk125(clk125), .reset(reset), .afull(afull), .rden(rden), .q(q),
    .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er)
  );

  crc32_d8 u_crc (
    .clk125(clk125), .reset(reset), .init(c_init), .en(c_en), .d(c_d), .crc(c_crc)
  );

  // FIFO read side: Q updates on the edge that samples rden.
  logic [39:0] fifo_mem [256];
  int          rd_ptr = 0;
  always @(posedge clk125) begin
    if (rden) begin
      q      <= fifo_mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Frame monitor: records every tx_en window, its rden offsets and the idle run before it.
  logic [7:0] fr_buf [16][2048];
  int fr_len [16];
  int fr_rd0 [16];
  int fr_gap [16];
  int fr_rn  [16];
  int fr_off [16][16];
  int fr_cnt = 0, fr_start = 0, cur_len = 0, cur_slot = 0, low_run = 0;
  int rden_outside = 0, rden_b2b = 0;
  logic prev_en = 1'b0, prev_rden = 1'b0;

  initial begin
    forever begin
      @(negedge clk125);
      if (tx_en === 1'b1) begin
        if (!prev_en) begin
          cur_slot = fr_start % 16;
          fr_gap[cur_slot] = low_run;
          fr_rd0[cur_slot] = rd_ptr;
          fr_rn[cur_slot]  = 0;
          cur_len = 0;
          fr_start++;
        end
        low_run = 0;
        if (cur_len < 2048) fr_buf[cur_slot][cur_len] = tx_data;
        if (rden === 1'b1) begin
          if (fr_rn[cur_slot] < 16) fr_off[cur_slot][fr_rn[cur_slot]] = cur_len;
          fr_rn[cur_slot]++;
        end
        cur_len++;
      end else begin
        if (prev_en) begin
          fr_len[cur_slot] = cur_len;
          fr_cnt++;
        end
        if (rden === 1'b1) rden_outside++;
        low_run++;
      end
      if (rden === 1'b1 && prev_rden) rden_b2b++;
      prev_en   = (tx_en === 1'b1);
      prev_rden = (rden === 1'b1);
    end
  end

  // Expected frame rebuilt from the frame format and the words the FIFO handed out.
  function automatic int frame_diff(input int slot, input logic [15:0] s);
    logic [7:0]  e [FLEN];
    logic [47:0] src;
    logic [39:0] w;
    logic [31:0] c;
    logic        fb;
    int          bad;
    bad = 0;
    src = 48'h02_00_00_00_00_01;
    for (int i = 0; i < 7; i++) e[i] = 8'h55;
    e[7] = 8'hD5;
    for (int i = 0; i < 6; i++) e[8 + i] = 8'hFF;
    for (int i = 0; i < 6; i++) e[14 + i] = src[47 - 8 * i -: 8];
    e[20] = 8'h88;
    e[21] = 8'hB5;
    e[22] = s[15:8];
    e[23] = s[7:0];
    for (int k = 0; k < W; k++) begin
      w = fifo_mem[(fr_rd0[slot] + k) % 256];
      for (int b = 0; b < 5; b++) e[24 + 5 * k + b] = w[39 - 8 * b -: 8];
    end
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 24 + 5 * W; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ e[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    c = ~c;
    for (int b = 0; b < 4; b++) e[24 + 5 * W + b] = c[8 * b +: 8];
    if (fr_len[slot] != FLEN) bad++;
    for (int i = 0; i < FLEN; i++) if (fr_buf[slot][i] !== e[i]) bad++;
    return bad;
  endfunction

  function automatic int rden_diff(input int slot);
    int bad;
    bad = (fr_rn[slot] != W) ? 1 : 0;
    for (int k = 0; k < W && k < 16; k++) if (fr_off[slot][k] != 8 + 13 + 5 * k) bad++;
    return bad;
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk125);
      #1;
      if (((which == 0) ? fr_cnt : fr_start) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk125);
    reset = 1'b1;
    repeat (3) @(negedge clk125);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int st;
    reset = 1'b1;
    afull = 1'b1;
    repeat (3) @(posedge clk125);
    #1;
    checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    checks++; if (rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", rden); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (tx_er !== 1'b0) begin failures++; $display("FAIL reset_tx_er got=%b exp=0", tx_er); end
    st = fr_start;
    afull = 1'b0;
    @(negedge clk125);
    reset = 1'b0;
    repeat (20) @(negedge clk125);
    checks++; if (fr_start !== st) begin failures++; $display("FAIL idle_no_frame got=%0d exp=%0d", fr_start, st); end
  endtask

  task automatic test_crc_check();
    string s;
    s = "123456789";
    @(negedge clk125);
    c_init = 1'b1;
    @(negedge clk125);
    c_init = 1'b0;
    checks++; if (c_crc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL crc_init got=%h exp=ffffffff", c_crc); end
    for (int i = 0; i < 9; i++) begin
      c_d  = s[i];
      c_en = 1'b1;
      @(negedge clk125);
    end
    c_en = 1'b0;
    checks++; if (~c_crc !== 32'hCBF4_3926) begin failures++; $display("FAIL crc_check got=%h exp=cbf43926", ~c_crc); end
  endtask

  task automatic test_single_frame();
    int st, slot, bad, out0, b2b0;
    bit ok;
    st = fr_start; slot = st % 16; out0 = rden_outside; b2b0 = rden_b2b;
    @(negedge clk125);
    afull = 1'b1;
    @(posedge clk125);
    #1;
    afull = 1'b0;
    checks++; if (tx_en !== 1'b1 || tx_data !== 8'h55) begin failures++; $display("FAIL start_latency got=%b/%h exp=1/55", tx_en, tx_data); end
    wait_for(0, fr_cnt + 1, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d exp=1", ok); end
    checks++; if (fr_len[slot] !== FLEN) begin failures++; $display("FAIL single_len got=%0d exp=%0d", fr_len[slot], FLEN); end
    bad = 0;
    for (int j = 0; j < 5 * W; j++) if (fr_buf[slot][24 + j] !== 8'(j + 1)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_payload got=%0d_bad exp=0", bad); end
    checks++; if ({fr_buf[slot][22], fr_buf[slot][23]} !== 16'h0000) begin failures++; $display("FAIL single_seq got=%h%h exp=0000", fr_buf[slot][22], fr_buf[slot][23]); end
    bad = frame_diff(slot, 16'h0000);
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_frame got=%0d_bad exp=0", bad); end
    bad = rden_diff(slot);
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_rden got=%0d_bad count=%0d exp=0", bad, fr_rn[slot]); end
    checks++; if (rden_outside !== out0 || rden_b2b !== b2b0) begin failures++; $display("FAIL single_rden_rules got=%0d/%0d exp=%0d/%0d", rden_outside, rden_b2b, out0, b2b0); end
    repeat (40) @(negedge clk125);
    checks++; if (fr_start !== st + 1) begin failures++; $display("FAIL single_one_frame got=%0d exp=%0d", fr_start - st, 1); end
  endtask

  task automatic test_back_to_back();
    int st, rd0, b2b0, bad, slot;
    bit ok;
    do_reset();
    st = fr_start; rd0 = rd_ptr; b2b0 = rden_b2b;
    @(negedge clk125);
    afull = 1'b1;
    wait_for(1, st + 3, 600, ok);
    afull = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL b2b_start_timeout got=%0d exp=1", ok); end
    wait_for(0, st + 3, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done_timeout got=%0d exp=1", ok); end
    for (int f = 0; f < 3; f++) begin
      slot = (st + f) % 16;
      bad = frame_diff(slot, 16'(f));
      checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_frame%0d got=%0d_bad exp=0", f, bad); end
      checks++; if ({fr_buf[slot][22], fr_buf[slot][23]} !== 16'(f)) begin failures++; $display("FAIL b2b_seq%0d got=%h%h exp=%0d", f, fr_buf[slot][22], fr_buf[slot][23], f); end
      if (f > 0) begin
        checks++; if (fr_gap[slot] !== 13) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=13", f, fr_gap[slot]); end
      end
    end
    checks++; if (rd_ptr - rd0 !== 3 * W) begin failures++; $display("FAIL b2b_rden_total got=%0d exp=%0d", rd_ptr - rd0, 3 * W); end
    checks++; if (rden_b2b !== b2b0) begin failures++; $display("FAIL b2b_rden_adjacent got=%0d exp=%0d", rden_b2b, b2b0); end
  endtask

  task automatic test_seq_wrap();
    int st, bad;
    bit ok;
    do_reset();
    st = fr_start;
    @(negedge clk125);
    force dut.seq = 16'hFFFF;
    repeat (2) @(negedge clk125);
    release dut.seq;
    afull = 1'b1;
    wait_for(1, st + 2, 400, ok);
    afull = 1'b0;
    wait_for(0, st + 2, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=%0d exp=1", ok); end
    bad = frame_diff(st % 16, 16'hFFFF);
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_ffff_frame got=%0d_bad exp=0", bad); end
    bad = frame_diff((st + 1) % 16, 16'h0000);
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_0000_frame got=%0d_bad exp=0", bad); end
    checks++; if ({fr_buf[(st + 1) % 16][22], fr_buf[(st + 1) % 16][23]} !== 16'h0000) begin failures++; $display("FAIL wrap_seq got=%h%h exp=0000", fr_buf[(st + 1) % 16][22], fr_buf[(st + 1) % 16][23]); end
  endtask

  task automatic test_reset_mid_frame();
    int st, slot, bad, cyc;
    bit ok;
    do_reset();
    st = fr_start;
    @(negedge clk125);
    afull = 1'b1;
    @(posedge clk125);
    #1;
    afull = 1'b0;
    cyc = 0;
    while (!(fr_start == st + 1 && cur_len >= 44) && cyc < 200) begin
      @(posedge clk125);
      #1;
      cyc++;
    end
    checks++; if (cyc >= 200) begin failures++; $display("FAIL midreset_timeout got=%0d exp=<200", cyc); end
    @(negedge clk125);
    reset = 1'b1;
    @(posedge clk125);
    #1;
    checks++; if (tx_en !== 1'b0 || rden !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b/%b exp=0/0", tx_en, rden); end
    repeat (2) @(negedge clk125);
    reset = 1'b0;
    afull = 1'b1;
    wait_for(1, st + 2, 200, ok);
    afull = 1'b0;
    wait_for(0, st + 2, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_restart_timeout got=%0d exp=1", ok); end
    checks++; if (fr_len[st % 16] >= FLEN) begin failures++; $display("FAIL midreset_truncated got=%0d exp=<%0d", fr_len[st % 16], FLEN); end
    slot = (st + 1) % 16;
    checks++; if (fr_buf[slot][0] !== 8'h55) begin failures++; $display("FAIL midreset_first_byte got=%h exp=55", fr_buf[slot][0]); end
    bad = frame_diff(slot, 16'h0000);
    checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_frame got=%0d_bad exp=0", bad); end
  endtask

  task automatic test_afull_drop();
    int st, bad;
    bit ok;
    st = fr_start;
    @(negedge clk125);
    afull = 1'b1;
    wait_for(1, st + 1, 100, ok);
    afull = 1'b0;
    wait_for(0, st + 1, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_timeout got=%0d exp=1", ok); end
    bad = frame_diff(st % 16, 16'h0001);
    checks++; if (bad !== 0) begin failures++; $display("FAIL drop_frame got=%0d_bad exp=0", bad); end
    bad = rden_diff(st % 16);
    checks++; if (bad !== 0) begin failures++; $display("FAIL drop_rden got=%0d_bad count=%0d exp=0", bad, fr_rn[st % 16]); end
    repeat (60) @(negedge clk125);
    checks++; if (fr_start !== st + 1) begin failures++; $display("FAIL drop_no_restart got=%0d exp=%0d", fr_start - st, 1); end
    afull = 1'b1;
    wait_for(1, st + 2, 50, ok);
    afull = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL drop_resume got=%0d exp=1", ok); end
    wait_for(0, st + 2, 300, ok);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      fifo_mem[i] = {8'($urandom), $urandom};
    end
    for (int i = 0; i < W; i++) begin
      fifo_mem[i] = 40'h01_0203_0405 + 40'h05_0505_0505 * 40'(i);
    end
    test_reset();
    test_crc_check();
    test_single_frame();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid_frame();
    test_afull_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
